// File: rtl/serializer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serializer_pkg
// Description : Shared state type, default width and parity helper for the
//               word serializer.
// Revision    : 1.0 - initial release
// ============================================================================
package serializer_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } ser_state_e;

  // Zero-extended words keep their parity, so one fixed-width helper serves any WIDTH <= 64.
  function automatic logic even_parity(input logic [63:0] word);
    return ^word;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ser_bit_counter.sv
`default_nettype none
// ============================================================================
// Module      : ser_bit_counter
// Description : Load/enable bit counter, saturating at MAX, with terminal and
//               one-before-terminal flags.
// Revision    : 1.0 - initial release
// ============================================================================
module ser_bit_counter #(
  parameter int MAX = 3,
  parameter int CW  = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  input  logic en,
  output logic tc,
  output logic pre_tc
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (en && (cnt_q != CW'(MAX))) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc     = (cnt_q == CW'(MAX));
  assign pre_tc = (cnt_q == CW'(MAX - 1));

endmodule
`default_nettype wire

// File: rtl/serial_word_serializer.sv
`default_nettype none
// ============================================================================
// Module      : serial_word_serializer
// Description : Valid/ready parallel word in, registered bit-serial stream out
//               with per-bit valid and last markers, zero-gap back-to-back.
//               Optional macro SERIALIZER_PARITY_EN appends an even-parity bit.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_word_serializer
  import serializer_pkg::*;
#(
  parameter int   WIDTH      = DEFAULT_WIDTH,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] par_data,
  input  logic             par_valid,
  output logic             par_ready,
  output logic             ser_d,
  output logic             ser_valid,
  output logic             ser_last,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  ser_state_e       state_q, state_d;
  // Holds the bits still to be sent after the one currently on ser_d.
  logic [WIDTH-2:0] sreg_q, sreg_d;
  logic             ser_d_q, ser_d_d;
  logic             ser_valid_q, ser_valid_d;
  logic             ser_last_q, ser_last_d;

  logic             first_bit;
  logic [WIDTH-2:0] first_rest;
  logic             next_bit;
  logic [WIDTH-2:0] sreg_adv;
  logic             accept;
  logic             cnt_load;
  logic             cnt_en;
  logic             cnt_tc;
  logic             cnt_pre_tc;

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign first_bit  = par_data[WIDTH-1];
      assign first_rest = par_data[WIDTH-2:0];
      assign next_bit   = sreg_q[WIDTH-2];
      assign sreg_adv   = sreg_q << 1;
    end else begin : g_lsb_first
      assign first_bit  = par_data[0];
      assign first_rest = par_data[WIDTH-1:1];
      assign next_bit   = sreg_q[0];
      assign sreg_adv   = sreg_q >> 1;
    end
  endgenerate

  ser_bit_counter #(
    .MAX (WIDTH - 1),
    .CW  (CNT_W)
  ) u_bit_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (cnt_load),
    .en      (cnt_en),
    .tc      (cnt_tc),
    .pre_tc  (cnt_pre_tc)
  );

`ifdef SERIALIZER_PARITY_EN
  logic parity_q, parity_d;

  assign par_ready = (state_q == IDLE) || (state_q == PARITY);
`else
  assign par_ready = (state_q == IDLE) || ((state_q == SHIFT) && cnt_tc);
`endif

  assign accept = par_valid && par_ready;

  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    ser_d_d     = IDLE_LEVEL;
    ser_valid_d = 1'b0;
    ser_last_d  = 1'b0;
    cnt_load    = 1'b0;
    cnt_en      = 1'b0;
`ifdef SERIALIZER_PARITY_EN
    parity_d    = parity_q;
`endif

    case (state_q)
      SHIFT: begin
        if (!cnt_tc) begin
          sreg_d      = sreg_adv;
          ser_d_d     = next_bit;
          ser_valid_d = 1'b1;
          cnt_en      = 1'b1;
`ifdef SERIALIZER_PARITY_EN
          ser_last_d  = 1'b0;
`else
          ser_last_d  = cnt_pre_tc;
`endif
        end else begin
`ifdef SERIALIZER_PARITY_EN
          state_d     = PARITY;
          ser_d_d     = parity_q;
          ser_valid_d = 1'b1;
          ser_last_d  = 1'b1;
`else
          state_d     = IDLE;
`endif
        end
      end
`ifdef SERIALIZER_PARITY_EN
      PARITY: begin
        state_d = IDLE;
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase

    // A handshake always starts a fresh frame, overriding the drain-to-idle path.
    if (accept) begin
      state_d     = SHIFT;
      sreg_d      = first_rest;
      ser_d_d     = first_bit;
      ser_valid_d = 1'b1;
      ser_last_d  = 1'b0;
      cnt_load    = 1'b1;
`ifdef SERIALIZER_PARITY_EN
      parity_d    = even_parity(64'(par_data));
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      sreg_q      <= '0;
      ser_d_q     <= IDLE_LEVEL;
      ser_valid_q <= 1'b0;
      ser_last_q  <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      ser_d_q     <= ser_d_d;
      ser_valid_q <= ser_valid_d;
      ser_last_q  <= ser_last_d;
`ifdef SERIALIZER_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

  assign ser_d     = ser_d_q;
  assign ser_valid = ser_valid_q;
  assign ser_last  = ser_last_q;
  assign busy      = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_serial_word_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_word_serializer
// Description : Self-checking bench for serial_word_serializer; MSB-first and
//               LSB-first instances against a bit-queue reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_word_serializer;

  localparam int W = 4;
`ifdef SERIALIZER_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] par_data = '0;
  logic         par_valid = 1'b0;

  logic a_ready, a_d, a_valid, a_last, a_busy;
  logic b_ready, b_d, b_valid, b_last, b_busy;

  int tests = 0;
  int fails = 0;

  // Model: each queue holds {bit, last} for bits still to appear; entry 0 is on ser_d now.
  logic [1:0] qa[$];
  logic [1:0] qb[$];
  logic       last_acc;

  always #5 clk = ~clk;

  serial_word_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_msb (
    .clk(clk), .reset_n(reset_n), .par_data(par_data), .par_valid(par_valid),
    .par_ready(a_ready), .ser_d(a_d), .ser_valid(a_valid), .ser_last(a_last), .busy(a_busy)
  );

  serial_word_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_lsb (
    .clk(clk), .reset_n(reset_n), .par_data(par_data), .par_valid(par_valid),
    .par_ready(b_ready), .ser_d(b_d), .ser_valid(b_valid), .ser_last(b_last), .busy(b_busy)
  );

  // Expected {valid, d, last, busy, ready} from model queue size and head entry.
  function automatic logic [4:0] exp_vec(input int sz, input logic [1:0] head);
    if (sz == 0) return 5'b00001;
    return {1'b1, head[1], head[0], 1'b1, (sz <= 1)};
  endfunction

  // Applies inputs for one cycle and advances the model; no checking here.
  task automatic drive(input logic v, input logic [W-1:0] d);
    logic       acc;
    logic [1:0] dummy;
    par_valid = v;
    par_data  = d;
    @(posedge clk);
    acc = v && (qa.size() <= 1);
    if (qa.size() > 0) begin
      dummy = qa.pop_front();
      dummy = qb.pop_front();
    end
    if (acc) begin
      for (int i = 0; i < W; i++) begin
        qa.push_back({d[W-1-i], (i == W-1) && !PAR});
        qb.push_back({d[i],     (i == W-1) && !PAR});
      end
      if (PAR) begin
        qa.push_back({^d, 1'b1});
        qb.push_back({^d, 1'b1});
      end
    end
    last_acc = acc;
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    #1;
    tests++;
    if ({a_valid, a_d, a_last, a_busy} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_msb: got %b want 0000", {a_valid, a_d, a_last, a_busy});
    end
    tests++;
    if ({b_valid, b_d, b_last, b_busy} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_lsb: got %b want 0000", {b_valid, b_d, b_last, b_busy});
    end
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    tests++;
    if ({a_valid, a_d, a_last, a_busy, a_ready} !== 5'b00001) begin
      fails++;
      $display("FAIL reset_release: got %b want 00001", {a_valid, a_d, a_last, a_busy, a_ready});
    end
    @(negedge clk);
  endtask

  task automatic test_word(input string name, input logic [W-1:0] word);
    for (int i = 0; i < W + 4; i++) begin
      drive(i == 0, word);
      tests++;
      if ({a_valid, a_d, a_last, a_busy, a_ready} !== exp_vec(qa.size(), qa.size() > 0 ? qa[0] : 2'b00)) begin
        fails++;
        $display("FAIL %s_msb cyc %0d: got %b want %b", name, i,
                 {a_valid, a_d, a_last, a_busy, a_ready}, exp_vec(qa.size(), qa.size() > 0 ? qa[0] : 2'b00));
      end
      tests++;
      if ({b_valid, b_d, b_last, b_busy, b_ready} !== exp_vec(qb.size(), qb.size() > 0 ? qb[0] : 2'b00)) begin
        fails++;
        $display("FAIL %s_lsb cyc %0d: got %b want %b", name, i,
                 {b_valid, b_d, b_last, b_busy, b_ready}, exp_vec(qb.size(), qb.size() > 0 ? qb[0] : 2'b00));
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] words [2];
    int idx = 0;
    words[0] = 4'b1100;
    words[1] = 4'b0011;
    for (int i = 0; i < 3 * W + 4; i++) begin
      drive(idx < 2, words[idx < 2 ? idx : 1]);
      if (last_acc) idx++;
      tests++;
      if ({a_valid, a_d, a_last, a_busy, a_ready} !== exp_vec(qa.size(), qa.size() > 0 ? qa[0] : 2'b00)) begin
        fails++;
        $display("FAIL b2b_msb cyc %0d: got %b want %b", i,
                 {a_valid, a_d, a_last, a_busy, a_ready}, exp_vec(qa.size(), qa.size() > 0 ? qa[0] : 2'b00));
      end
      tests++;
      if ({b_valid, b_d, b_last, b_busy, b_ready} !== exp_vec(qb.size(), qb.size() > 0 ? qb[0] : 2'b00)) begin
        fails++;
        $display("FAIL b2b_lsb cyc %0d: got %b want %b", i,
                 {b_valid, b_d, b_last, b_busy, b_ready}, exp_vec(qb.size(), qb.size() > 0 ? qb[0] : 2'b00));
      end
    end
  endtask

  task automatic test_reset_mid_frame;
    drive(1'b1, 4'b1111);
    drive(1'b0, 4'b0000);
    tests++;
    if ({a_valid, a_d, a_busy} !== 3'b111) begin
      fails++;
      $display("FAIL midrst_pre: got %b want 111", {a_valid, a_d, a_busy});
    end
    reset_n = 1'b0;
    #1;
    qa.delete();
    qb.delete();
    tests++;
    if ({a_valid, a_d, a_last, a_busy} !== 4'b0000) begin
      fails++;
      $display("FAIL midrst_msb: got %b want 0000", {a_valid, a_d, a_last, a_busy});
    end
    tests++;
    if ({b_valid, b_d, b_last, b_busy} !== 4'b0000) begin
      fails++;
      $display("FAIL midrst_lsb: got %b want 0000", {b_valid, b_d, b_last, b_busy});
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < W + 3; i++) begin
      drive(i == 0, 4'b0110);
      tests++;
      if ({a_valid, a_d, a_last, a_busy, a_ready} !== exp_vec(qa.size(), qa.size() > 0 ? qa[0] : 2'b00)) begin
        fails++;
        $display("FAIL midrst_after cyc %0d: got %b want %b", i,
                 {a_valid, a_d, a_last, a_busy, a_ready}, exp_vec(qa.size(), qa.size() > 0 ? qa[0] : 2'b00));
      end
    end
  endtask

  task automatic test_busy_pulse;
    for (int i = 0; i < W + 4; i++) begin
      // Pulses during non-final bits must be ignored; word 1001 must never appear.
      drive(i == 0 || i == 1 || i == 2, (i == 0) ? 4'b0110 : 4'b1001);
      tests++;
      if ({a_valid, a_d, a_last, a_busy, a_ready} !== exp_vec(qa.size(), qa.size() > 0 ? qa[0] : 2'b00)) begin
        fails++;
        $display("FAIL busy_pulse_msb cyc %0d: got %b want %b", i,
                 {a_valid, a_d, a_last, a_busy, a_ready}, exp_vec(qa.size(), qa.size() > 0 ? qa[0] : 2'b00));
      end
      tests++;
      if ({b_valid, b_d, b_last, b_busy, b_ready} !== exp_vec(qb.size(), qb.size() > 0 ? qb[0] : 2'b00)) begin
        fails++;
        $display("FAIL busy_pulse_lsb cyc %0d: got %b want %b", i,
                 {b_valid, b_d, b_last, b_busy, b_ready}, exp_vec(qb.size(), qb.size() > 0 ? qb[0] : 2'b00));
      end
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 99) < 65, W'($urandom));
      tests++;
      if ({a_valid, a_d, a_last, a_busy, a_ready} !== exp_vec(qa.size(), qa.size() > 0 ? qa[0] : 2'b00)) begin
        fails++;
        $display("FAIL random_msb cyc %0d: got %b want %b", i,
                 {a_valid, a_d, a_last, a_busy, a_ready}, exp_vec(qa.size(), qa.size() > 0 ? qa[0] : 2'b00));
      end
      tests++;
      if ({b_valid, b_d, b_last, b_busy, b_ready} !== exp_vec(qb.size(), qb.size() > 0 ? qb[0] : 2'b00)) begin
        fails++;
        $display("FAIL random_lsb cyc %0d: got %b want %b", i,
                 {b_valid, b_d, b_last, b_busy, b_ready}, exp_vec(qb.size(), qb.size() > 0 ? qb[0] : 2'b00));
      end
    end
  endtask

  initial begin
    last_acc = 1'b0;
    test_reset();
    test_word("single_1010", 4'b1010);
    test_back_to_back();
    test_word("word_1000", 4'b1000);
    test_reset_mid_frame();
    test_busy_pulse();
    test_word("word_1011", 4'b1011);
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
